// File: rtl/eot_arbiter_if.sv
// eot_arbiter_if: producer-side and consumer-side stream signals of the eot arbiter.
// The arbiter uses the slave modport; the environment that drives producers and
// the downstream consumer uses the master modport.
interface eot_arbiter_if #(
   parameter int unsigned N      = 4,
   parameter int unsigned W_DATA = 16,
   parameter int unsigned W_SEL  = $clog2(N)
);
   logic [N*W_DATA-1:0] din_data;
   logic [N-1:0]        din_valid;
   logic [N-1:0]        din_ready;
   logic [W_DATA-1:0]   dout_data;
   logic [W_SEL-1:0]    dout_sel;
   logic                dout_valid;
   logic                dout_ready;
   logic                busy;
   logic [15:0]         pkt_cnt;

   modport slave (
      input  din_data, din_valid, dout_ready,
      output din_ready, dout_data, dout_sel, dout_valid, busy, pkt_cnt
   );

   modport master (
      output din_data, din_valid, dout_ready,
      input  din_ready, dout_data, dout_sel, dout_valid, busy, pkt_cnt
   );
endinterface

// File: rtl/eot_arbiter.sv
// eot_arbiter: merges N producer streams into one, keeping every transaction
// contiguous. A granted channel owns the output until its eot beat handshakes;
// one IDLE cycle then re-arbitrates. Round-robin by default; defining
// EOT_ARB_FIXED_PRIO_EN selects lowest-index-wins priority instead.
module eot_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned W_DATA = 16,
   parameter int unsigned W_SEL  = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   eot_arbiter_if.slave bus
);
   localparam int unsigned W_CNT = 16;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [W_SEL-1:0]  r_grant;
   logic [W_SEL-1:0]  w_grant_nx;
   logic [W_SEL-1:0]  r_last;
   logic [W_SEL-1:0]  w_last_nx;
   logic [W_SEL-1:0]  w_winner;
   logic [W_CNT-1:0]  r_pkt_cnt;
   logic [W_CNT-1:0]  w_pkt_cnt_nx;
   logic [N-1:0]      w_din_ready;
   logic              w_dout_valid;
   logic [W_DATA-1:0] w_ch_data [N];
   logic [W_DATA-1:0] w_beat;
   logic              w_beat_valid;

   // Split the flat input bus into per-channel beats
   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         w_ch_data[i] = bus.din_data[i*W_DATA +: W_DATA];
      end
   end

   assign w_beat       = w_ch_data[r_grant];
   assign w_beat_valid = bus.din_valid[r_grant];

`ifdef EOT_ARB_FIXED_PRIO_EN
   // Lowest-indexed requester wins
   always_comb begin
      w_winner = r_last;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (bus.din_valid[i]) w_winner = W_SEL'(i);
      end
   end
`else
   logic [W_SEL-1:0] w_idx;

   // First requester after the previous owner, with wrap-around
   always_comb begin
      w_winner = r_last;
      w_idx    = '0;
      for (int k = int'(N); k >= 1; k--) begin
         w_idx = W_SEL'((int'(r_last) + k) % int'(N));
         if (bus.din_valid[w_idx]) w_winner = w_idx;
      end
   end
`endif

   // Next-state and handshake steering
   always_comb begin
      w_state_nx   = r_state;
      w_grant_nx   = r_grant;
      w_last_nx    = r_last;
      w_pkt_cnt_nx = r_pkt_cnt;
      w_din_ready  = '0;
      w_dout_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|bus.din_valid) begin
               w_grant_nx = w_winner;
               w_state_nx = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            w_dout_valid         = w_beat_valid;
            w_din_ready[r_grant] = bus.dout_ready;
            if (w_beat_valid && bus.dout_ready && w_beat[W_DATA-1]) begin
               w_last_nx    = r_grant;
               w_pkt_cnt_nx = r_pkt_cnt + W_CNT'(1);
               w_state_nx   = ST_IDLE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // State registers; reset points last at N-1 so channel 0 wins first
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_last    <= W_SEL'(N - 1);
         r_pkt_cnt <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_grant   <= w_grant_nx;
         r_last    <= w_last_nx;
         r_pkt_cnt <= w_pkt_cnt_nx;
      end
   end

   assign bus.din_ready  = w_din_ready;
   assign bus.dout_data  = w_beat;
   assign bus.dout_sel   = r_grant;
   assign bus.dout_valid = w_dout_valid;
   assign bus.busy       = (r_state == ST_LOCKED);
   assign bus.pkt_cnt    = r_pkt_cnt;
endmodule

// File: tb/tb_eot_arbiter.sv
// tb_eot_arbiter: directed vector table, scripted corner sequences and a
// randomized run scored against a packet-level arbitration model.
module tb_eot_arbiter;
   localparam int unsigned N = 4;
   localparam int unsigned W = 16;

   logic clk;
   logic rst;

   eot_arbiter_if #(.N(N), .W_DATA(W)) bus ();
   eot_arbiter #(.N(N), .W_DATA(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [3:0]  vld;
      logic [15:0] dat;
      logic        rdy;
      logic        e_v;
      logic [15:0] e_d;
      logic [1:0]  e_sel;
      logic        e_busy;
      logic [3:0]  e_rdy;
      logic [15:0] e_cnt;
   } vec_t;

   typedef struct {
      int          sel;
      logic [15:0] data;
   } beat_t;

   vec_t        tbl [$];
   logic [15:0] chq [N][$];
   bit          midpkt [N];
   beat_t       exp_q [$];
   int          obs_grants [$];
   bit          out_first;
   int          model_last;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] vld, input logic [15:0] dat,
                      input logic rdy, input logic e_v, input logic [15:0] e_d,
                      input logic [1:0] e_sel, input logic e_busy,
                      input logic [3:0] e_rdy, input logic [15:0] e_cnt);
      vec_t v;
      v.r = r; v.vld = vld; v.dat = dat; v.rdy = rdy; v.e_v = e_v; v.e_d = e_d;
      v.e_sel = e_sel; v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.din_valid  = '0;
      bus.din_data   = '0;
      bus.dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         chq[i].delete();
         midpkt[i] = 1'b0;
      end
      exp_q.delete();
      obs_grants.delete();
      out_first  = 1'b1;
      model_last = int'(N) - 1;
   endtask

   task automatic add_pkt(input int ch, input int len, input logic [14:0] base);
      for (int b = 0; b < len; b++)
         chq[ch].push_back({(b == len - 1), 15'(base + 15'(b))});
   endtask

   // Packet-level reference: whole transactions leave in arbitration order
   function automatic int build_expected();
      logic [15:0] cq [N][$];
      logic [15:0] b;
      beat_t       e;
      int          w;
      int          n = 0;
      for (int i = 0; i < int'(N); i++) cq[i] = chq[i];
      while (1) begin
         w = -1;
`ifdef EOT_ARB_FIXED_PRIO_EN
         for (int i = int'(N) - 1; i >= 0; i--)
            if (cq[i].size() > 0) w = i;
`else
         for (int k = int'(N); k >= 1; k--)
            if (cq[(model_last + k) % int'(N)].size() > 0) w = (model_last + k) % int'(N);
`endif
         if (w < 0) break;
         do begin
            b = cq[w].pop_front();
            e.sel = w; e.data = b;
            exp_q.push_back(e);
         end while (!b[15]);
         model_last = w;
         n++;
      end
      return n;
   endfunction

   // One clock of producers and consumer, scoring accepted output beats
   task automatic stream_cycle(input bit rnd);
      logic [N*W-1:0] d;
      logic [N-1:0]   v;
      logic [15:0]    b;
      beat_t          e;
      d = '0;
      v = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (chq[i].size() > 0) begin
            d[i*W +: W] = chq[i][0];
            if (!(rnd && midpkt[i] && ($urandom_range(0, 2) == 0))) v[i] = 1'b1;
         end
      end
      bus.din_valid  = v;
      bus.din_data   = d;
      bus.dout_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (bus.dout_valid && bus.dout_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_beat: got data 0x%0h sel %0d, expected no beat",
                     bus.dout_data, bus.dout_sel);
         end else begin
            e = exp_q.pop_front();
            chk("beat_sel", 32'(bus.dout_sel), 32'(e.sel));
            chk("beat_data", 32'(bus.dout_data), 32'(e.data));
            if (out_first) obs_grants.push_back(int'(bus.dout_sel));
            out_first = bus.dout_data[15];
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (bus.din_valid[i] && bus.din_ready[i] && chq[i].size() > 0) begin
            b = chq[i].pop_front();
            midpkt[i] = !b[15];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget, input bit rnd);
      int cyc = 0;
      while (exp_q.size() > 0 && cyc < budget) begin
         stream_cycle(rnd);
         cyc++;
      end
      chk("drain_beats_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_order(input string nm, input int exp [6]);
      if (obs_grants.size() < 6) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got %0d grants expected 6", nm, obs_grants.size());
      end else begin
         for (int k = 0; k < 6; k++)
            chk($sformatf("%s_%0d", nm, k), 32'(obs_grants[k]), 32'(exp[k]));
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n;
      logic [15:0] c0;
      int          ord [6];

      do_reset();

      // r vld dat rdy | e_v e_d e_sel e_busy e_rdy e_cnt
      add(0, 4'b0100, 16'h0011, 1, 0, 16'h0000, 0, 0, 4'b0000, 0);  // reset state, ch2 req
      add(0, 4'b0100, 16'h0011, 1, 1, 16'h0011, 2, 1, 4'b0100, 0);
      add(0, 4'b0100, 16'h0022, 1, 1, 16'h0022, 2, 1, 4'b0100, 0);
      add(0, 4'b0100, 16'h8033, 1, 1, 16'h8033, 2, 1, 4'b0100, 0);
      add(0, 4'b0000, 16'h0000, 1, 0, 16'h0000, 2, 0, 4'b0000, 1);  // busy drops
      add(0, 4'b0001, 16'h0001, 1, 0, 16'h0000, 2, 0, 4'b0000, 1);  // lock-hold case
      add(0, 4'b0001, 16'h0001, 1, 1, 16'h0001, 0, 1, 4'b0001, 1);
      for (int k = 0; k < 5; k++)
         add(0, 4'b0010, 16'h0005, 1, 0, 16'h0000, 0, 1, 4'b0001, 1);
      add(0, 4'b0011, 16'h8002, 1, 1, 16'h8002, 0, 1, 4'b0001, 1);
      add(0, 4'b0010, 16'h8002, 1, 0, 16'h0000, 0, 0, 4'b0000, 2);  // bubble
      add(0, 4'b0010, 16'h8002, 1, 1, 16'h8002, 1, 1, 4'b0010, 2);  // ch1 next
      add(0, 4'b0000, 16'h0000, 1, 0, 16'h0000, 1, 0, 4'b0000, 3);
      add(0, 4'b1000, 16'h00A1, 0, 0, 16'h0000, 1, 0, 4'b0000, 3);  // backpressure
      for (int k = 0; k < 4; k++)
         add(0, 4'b1000, 16'h00A1, 0, 1, 16'h00A1, 3, 1, 4'b0000, 3);
      add(0, 4'b1000, 16'h00A1, 1, 1, 16'h00A1, 3, 1, 4'b1000, 3);
      add(0, 4'b1000, 16'h80A2, 1, 1, 16'h80A2, 3, 1, 4'b1000, 3);
      add(0, 4'b0000, 16'h0000, 1, 0, 16'h0000, 3, 0, 4'b0000, 4);
      add(0, 4'b1000, 16'h00B1, 1, 0, 16'h0000, 3, 0, 4'b0000, 4);  // reset mid-packet
      add(0, 4'b1000, 16'h00B1, 1, 1, 16'h00B1, 3, 1, 4'b1000, 4);
      add(1, 4'b1000, 16'h00B2, 1, 1, 16'h00B2, 3, 1, 4'b1000, 4);
      add(0, 4'b1001, 16'h00B3, 1, 0, 16'h0000, 0, 0, 4'b0000, 0);
      add(0, 4'b1001, 16'h80B3, 1, 1, 16'h80B3, 0, 1, 4'b0001, 0);
      add(0, 4'b0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 4'b0000, 1);

      foreach (tbl[k]) begin
         rst            = tbl[k].r;
         bus.din_valid  = tbl[k].vld;
         bus.din_data   = {4{tbl[k].dat}};
         bus.dout_ready = tbl[k].rdy;
         @(negedge clk);
         chk($sformatf("v%0d_valid", k), 32'(bus.dout_valid), 32'(tbl[k].e_v));
         chk($sformatf("v%0d_sel", k), 32'(bus.dout_sel), 32'(tbl[k].e_sel));
         chk($sformatf("v%0d_busy", k), 32'(bus.busy), 32'(tbl[k].e_busy));
         chk($sformatf("v%0d_din_ready", k), 32'(bus.din_ready), 32'(tbl[k].e_rdy));
         chk($sformatf("v%0d_pkt_cnt", k), 32'(bus.pkt_cnt), 32'(tbl[k].e_cnt));
         if (tbl[k].e_v)
            chk($sformatf("v%0d_data", k), 32'(bus.dout_data), 32'(tbl[k].e_d));
         @(posedge clk);
         #1;
      end
      rst = 1'b0;

      // All channels stream 2-beat transactions back to back
      do_reset();
      for (int p = 0; p < 2; p++)
         for (int c = 0; c < int'(N); c++)
            add_pkt(c, 2, 15'(c * 64 + p * 8));
      n = build_expected();
      repeat (18) stream_cycle(1'b0);
      chk("fair_pkt_cnt_18cyc", 32'(bus.pkt_cnt), 32'd6);
`ifdef EOT_ARB_FIXED_PRIO_EN
      ord = '{0, 0, 1, 1, 2, 2};
`else
      ord = '{0, 1, 2, 3, 0, 1};
`endif
      check_order("fair_order", ord);
      drain(200, 1'b0);
      chk("fair_pkt_cnt_end", 32'(bus.pkt_cnt), 32'(n));

      // ch1 and ch3 both requesting continuously
      do_reset();
      for (int p = 0; p < 3; p++) begin
         add_pkt(1, 1, 15'(16'h100 + p));
         add_pkt(3, 1, 15'(16'h300 + p));
      end
      n = build_expected();
      drain(200, 1'b0);
`ifdef EOT_ARB_FIXED_PRIO_EN
      ord = '{1, 1, 1, 3, 3, 3};
`else
      ord = '{1, 3, 1, 3, 1, 3};
`endif
      check_order("prio_order", ord);
      chk("prio_pkt_cnt", 32'(bus.pkt_cnt), 32'(n));

      // Randomized traffic with stalls on both sides
      do_reset();
      for (int round = 0; round < 25; round++) begin
         c0 = bus.pkt_cnt;
         for (int c = 0; c < int'(N); c++) begin
            int np = int'($urandom_range(0, 2));
            for (int p = 0; p < np; p++)
               add_pkt(c, int'($urandom_range(1, 4)), 15'($urandom));
         end
         n = build_expected();
         drain(2000, 1'b1);
         chk($sformatf("rnd%0d_pkt_cnt", round), 32'(bus.pkt_cnt), 32'(16'(c0 + 16'(n))));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/eot_arbiter.md
# eot_arbiter

Packet-level arbiter that merges N dti-style producer streams into one output stream, never interleaving beats of different transactions. A channel, once granted, owns the output until a beat with its eot bit set completes a handshake; only then is the next channel chosen. It sits ahead of eot-gated consumers such as the release-after-eot gate, so each downstream transaction arrives contiguous and tagged with its source index.

## Interface
Parameters:
- N, default 4: number of input channels, legal range 2..8.
- W_DATA, default 16: beat width. Bit W_DATA-1 is eot. Bits W_DATA-2:0 are payload.
- W_SEL, default $clog2(N): channel index width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- din_data  input  N*W_DATA  channel i occupies bits [i*W_DATA +: W_DATA].
- din_valid  input  N  per-channel valid.
- din_ready  output  N  per-channel ready.
- dout_data  output  W_DATA  beat from the granted channel.
- dout_sel  output  W_SEL  index of the granted channel.
- dout_valid  output  1  output valid.
- dout_ready  input  1  output ready.
- busy  output  1  high while in LOCKED.
- pkt_cnt  output  16  count of completed transactions (eot handshakes). Wraps modulo 2^16.

## Operation
- The FSM has two states: IDLE and LOCKED.
- Registers: state, grant (W_SEL), last (W_SEL), pkt_cnt.
- IDLE:
  - din_ready = 0 and dout_valid = 0.
  - If any din_valid bit is set, load grant with the winner and go to LOCKED.
  - If no din_valid bit is set, stay in IDLE.
- Round-robin winner: the first channel with valid set, searching from index (last+1) mod N upward with wrap-around.
- LOCKED:
  - dout_data = din_data slice [grant].
  - dout_sel = grant.
  - dout_valid = din_valid[grant].
  - din_ready[grant] = dout_ready. All other din_ready bits are 0.
  - A handshake is dout_valid && dout_ready.
  - On a handshake with eot = 1: last <= grant, pkt_cnt <= pkt_cnt + 1, state <= IDLE.
  - On a handshake with eot = 0: stay in LOCKED.
- Lock hold: the lock is held while din_valid[grant] is deasserted mid-transaction. Other channels stay blocked regardless of their valid.
- Single-beat transactions (eot set on the first beat) are legal. They use one IDLE cycle plus one LOCKED cycle.
- Requesters other than the granted one see ready = 0. They must hold valid and data stable; the arbiter relies on this dti rule.
- dout_data and dout_sel are driven from grant in every state, including IDLE. They are only meaningful while dout_valid = 1.

## Timing
- Reset values: state IDLE, grant 0, last N-1 (so channel 0 wins first under round-robin), pkt_cnt 0.
- Output reset values: busy 0, dout_valid 0, din_ready all 0, dout_sel 0.
- Arbitration latency: one cycle. Valid seen in IDLE at cycle t means the first beat can be accepted at cycle t+1.
- Data path: combinational from din to dout in LOCKED. No added beat latency.
- Inter-packet bubble: exactly one cycle (the IDLE cycle) after every eot handshake, even when requests are pending.
- Throughput: back-to-back transactions of L beats sustain L beats per L+1 cycles.
- Simultaneous events:
  - A new request arriving in the same cycle as an eot handshake is evaluated in the following IDLE cycle.
  - If the current channel re-requests, it is evaluated with normal round-robin order and is not favoured.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. The partial transaction is abandoned; no eot is emitted on its behalf.

## Configuration
- EOT_ARB_FIXED_PRIO_EN:
  - Defined: the IDLE winner is the lowest-indexed channel with valid set. last is not used for selection, but is still updated.
  - Undefined (default): round-robin as described in Operation.
- All other behaviour, including pkt_cnt and busy, is identical with or without the macro.

## Test plan
- Single channel, N=4: ch2 sends 3 beats 0x0011, 0x0022, 0x8033 with dout_ready=1 -> IDLE cycle, then 3 beats with dout_sel=2, pkt_cnt=1, busy drops the cycle after 0x8033.
- Round-robin fairness: all 4 channels continuously send 2-beat transactions (second beat eot) -> grant order 0,1,2,3,0,1; pkt_cnt=6 after 18 cycles.
- Lock hold: ch0 sends a non-eot beat, drops valid for 5 cycles, and ch1 is valid throughout -> din_ready[1] stays 0. ch0's eot beat then completes and ch1 is granted next.
- Backpressure: dout_ready=0 for 4 cycles mid-transaction -> dout_data and dout_valid are stable, no beat is lost or duplicated, and the grant is unchanged.
- Reset mid-transaction: assert rst during beat 2 of 4 on ch3 -> next cycle dout_valid=0, pkt_cnt=0, and ch0 wins the next arbitration.
- Fixed priority (EOT_ARB_FIXED_PRIO_EN defined): ch1 and ch3 continuously requesting -> ch1 wins every arbitration and ch3 is starved.
